wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LOAD_TYPE_W, default 3, width of the load-type code.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: stall_mem, stall_wb  in  1 each  pipeline-control stall for the MEM and WB stages.
REQ-005 SHALL have ports: flush  in  1  exception flush.
REQ-006 SHALL have ports: mem_wd  in  5  destination register; mem_wreg  in  1  write request.
REQ-007 SHALL have ports: mem_wdata  in  32  ALU/move result; mem_reg2  in  32  old rt value for LWL/LWR.
REQ-008 SHALL have ports: mem_load_type  in  3  load code; mem_ram_data  in  32  data-RAM read word; mem_addr_lo  in  2  byte offset.
REQ-009 SHALL have ports: mem_ll_we  in  1  LLbit write request; mem_ll_value  in  1  LLbit write value.
REQ-010 SHALL have ports: wb_wd  out  5, wb_wreg  out  1, wb_wdata  out  32  drive the register file write port (waddr, we, wdata).
REQ-011 SHALL have ports: llbit_o  out  1  current LLbit, bypassed.

Function
REQ-012 SHALL register all MEM inputs into the WB register on each rising clk; end-to-end latency MEM->regfile write port is exactly 1 cycle.
REQ-013 SHALL compute wb_wdata combinationally from registered fields: NONE -> registered wdata; LW -> ram word.
REQ-014 SHALL treat memory as big-endian: offset 0 = ram[31:24], 3 = ram[7:0].
REQ-015 SHALL implement LB/LBU as the selected byte, sign-/zero-extended to 32 bits.
REQ-016 SHALL implement LH/LHU using addr_lo[1] (0 -> ram[31:16], 1 -> ram[15:0]), sign-/zero-extended; addr_lo[0] ignored (alignment trapped upstream).
REQ-017 SHALL implement LWL, offset n: ram bytes n..3 into the high bytes of the result, low n bytes from reg2 (n=0 -> ram word).
REQ-018 SHALL implement LWR, offset n: ram bytes 0..n into the low bytes of the result, high 3-n bytes from reg2 (n=3 -> ram word).
REQ-019 SHALL force wb_wdata to the registered value whenever wb_wreg=0 (no X on idle).
REQ-020 SHALL apply update priority flush > (stall_mem & !stall_wb) > !stall_mem > hold.
REQ-021 SHALL, on flush or (stall_mem & !stall_wb), load a bubble: wreg=0, wd=0, wdata=0, ll_we=0, load_type=NONE.
REQ-022 SHALL hold all WB register contents unchanged when stall_mem & stall_wb.
REQ-023 SHALL hold LLbit as a separate state bit, updated on rising clk: flush -> 0; else registered ll_we -> registered ll_value; else hold.
REQ-024 SHALL drive llbit_o = registered ll_value when registered ll_we=1 and flush=0, else LLbit (same-cycle bypass).
REQ-025 SHALL leave an LLbit write held in the WB register during a WB stall to repeat idempotently.

Reset
REQ-026 SHALL, when rst=1 at a rising clk, clear the WB register to the bubble value and LLbit to 0.
REQ-027 SHALL have outputs after reset: wb_wd=0, wb_wreg=0, wb_wdata=0, llbit_o=0.
REQ-028 SHALL give rst priority over flush and stall; a load in flight when rst asserts is discarded.

Structure
REQ-029 SHALL place load-type codes (NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7), ZeroWord, and the register-address width in the shared defines package.
REQ-030 SHALL place the alignment logic in one combinational sub-module, load_align (type, addr_lo, ram data, reg2 -> 32-bit result).
REQ-031 SHALL keep the pipeline register and LLbit in wb_stage itself.

Verification
REQ-032 SHALL cover: LB, addr_lo=1, ram=0x12F45678 -> next cycle wb_wdata=0xFFFFFFF4, wb_wreg=1.
REQ-033 SHALL cover: LBU same stimulus -> 0x000000F4; LHU addr_lo=2, ram=0x1234ABCD -> 0x0000ABCD.
REQ-034 SHALL cover: LWL addr_lo=1, ram=0x11223344, reg2=0xAABBCCDD -> 0x223344DD; LWR addr_lo=1 same data -> 0xAABB1122.
REQ-035 SHALL cover: stall_mem=1, stall_wb=0 for 1 cycle -> wb_wreg=0 bubble; stall_mem=stall_wb=1 for 2 cycles -> outputs frozen.
REQ-036 SHALL cover: LL (ll_we=1, value=1) -> llbit_o=1 in the WB cycle; flush on the next cycle -> llbit_o=0 and wb_wreg=0.
REQ-037 SHALL cover: rst asserted mid-LW -> all outputs 0 after the edge; the write never reaches the regfile.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module : wb_stage_pkg
// Brief  : Shared load-type codes and constants for the write-back stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_stage_pkg;

  localparam int unsigned c_REG_ADDR_W = 5;
  localparam logic [31:0] c_ZERO_WORD  = 32'h0000_0000;

  localparam logic [2:0] c_LOAD_NONE = 3'd0;
  localparam logic [2:0] c_LOAD_LB   = 3'd1;
  localparam logic [2:0] c_LOAD_LBU  = 3'd2;
  localparam logic [2:0] c_LOAD_LH   = 3'd3;
  localparam logic [2:0] c_LOAD_LHU  = 3'd4;
  localparam logic [2:0] c_LOAD_LW   = 3'd5;
  localparam logic [2:0] c_LOAD_LWL  = 3'd6;
  localparam logic [2:0] c_LOAD_LWR  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/wb_stage_align.sv
// ============================================================================
// Module : load_align
// Brief  : Big-endian load extraction/merge for byte, half, word, LWL, LWR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_align
  import wb_stage_pkg::*;
#(
  parameter int LOAD_TYPE_W = 3
) (
  input  logic [LOAD_TYPE_W-1:0] load_type_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [31:0]            ram_data_i,
  input  logic [31:0]            reg2_i,
  output logic [31:0]            result_o
);

  logic [2:0]  w_code;
  logic [4:0]  w_rsh;
  logic [4:0]  w_lsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lmask;
  logic [31:0] w_rmask;

  always_comb begin
    w_code  = 3'(load_type_i);
    // Offset 0 is the most significant byte, so the right-shift grows as n shrinks.
    w_rsh   = {2'(2'd3 - addr_lo_i), 3'b000};
    w_lsh   = {addr_lo_i, 3'b000};
    w_byte  = 8'(ram_data_i >> w_rsh);
    w_half  = addr_lo_i[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    w_lmask = 32'hFFFF_FFFF << w_lsh;
    w_rmask = 32'hFFFF_FFFF >> w_rsh;

    result_o = c_ZERO_WORD;
    case (w_code)
      c_LOAD_LB:  result_o = {{24{w_byte[7]}}, w_byte};
      c_LOAD_LBU: result_o = {24'h000000, w_byte};
      c_LOAD_LH:  result_o = {{16{w_half[15]}}, w_half};
      c_LOAD_LHU: result_o = {16'h0000, w_half};
      c_LOAD_LW:  result_o = ram_data_i;
      c_LOAD_LWL: result_o = (ram_data_i << w_lsh) | (reg2_i & ~w_lmask);
      c_LOAD_LWR: result_o = (ram_data_i >> w_rsh) | (reg2_i & ~w_rmask);
      default:    result_o = c_ZERO_WORD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module : wb_stage
// Brief  : MEM/WB pipeline register, load alignment and LLbit with bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LOAD_TYPE_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_mem,
  input  logic                    stall_wb,
  input  logic                    flush,
  input  logic [c_REG_ADDR_W-1:0] mem_wd,
  input  logic                    mem_wreg,
  input  logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_reg2,
  input  logic [LOAD_TYPE_W-1:0]  mem_load_type,
  input  logic [31:0]             mem_ram_data,
  input  logic [1:0]              mem_addr_lo,
  input  logic                    mem_ll_we,
  input  logic                    mem_ll_value,
  output logic [c_REG_ADDR_W-1:0] wb_wd,
  output logic                    wb_wreg,
  output logic [31:0]             wb_wdata,
  output logic                    llbit_o
);

  localparam logic [LOAD_TYPE_W-1:0] c_LT_NONE = LOAD_TYPE_W'(c_LOAD_NONE);

  logic [c_REG_ADDR_W-1:0] r_wd_q;
  logic                    r_wreg_q;
  logic [31:0]             r_wdata_q;
  logic [31:0]             r_reg2_q;
  logic [LOAD_TYPE_W-1:0]  r_lt_q;
  logic [31:0]             r_ram_q;
  logic [1:0]              r_lo_q;
  logic                    r_llwe_q;
  logic                    r_llval_q;
  logic                    r_llbit_q;
  logic                    w_bubble;
  logic                    w_load;
  logic [31:0]             w_align;

  assign w_bubble = flush | (stall_mem & ~stall_wb);
  assign w_load   = ~stall_mem;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_wd_q    <= '0;
      r_wreg_q  <= 1'b0;
      r_wdata_q <= c_ZERO_WORD;
      r_reg2_q  <= c_ZERO_WORD;
      r_lt_q    <= c_LT_NONE;
      r_ram_q   <= c_ZERO_WORD;
      r_lo_q    <= 2'b00;
      r_llwe_q  <= 1'b0;
      r_llval_q <= 1'b0;
    end else if (w_load) begin
      r_wd_q    <= mem_wd;
      r_wreg_q  <= mem_wreg;
      r_wdata_q <= mem_wdata;
      r_reg2_q  <= mem_reg2;
      r_lt_q    <= mem_load_type;
      r_ram_q   <= mem_ram_data;
      r_lo_q    <= mem_addr_lo;
      r_llwe_q  <= mem_ll_we;
      r_llval_q <= mem_ll_value;
    end
  end

  // A held LLbit write simply re-applies during a WB stall, which is harmless.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_llbit_q <= 1'b0;
    end else if (r_llwe_q) begin
      r_llbit_q <= r_llval_q;
    end
  end

  load_align #(
    .LOAD_TYPE_W (LOAD_TYPE_W)
  ) u_align (
    .load_type_i (r_lt_q),
    .addr_lo_i   (r_lo_q),
    .ram_data_i  (r_ram_q),
    .reg2_i      (r_reg2_q),
    .result_o    (w_align)
  );

  assign wb_wd    = r_wd_q;
  assign wb_wreg  = r_wreg_q;
  assign wb_wdata = (r_wreg_q && (r_lt_q != c_LT_NONE)) ? w_align : r_wdata_q;
  assign llbit_o  = (r_llwe_q && !flush) ? r_llval_q : r_llbit_q;

endmodule

`default_nettype wire
